// File: rtl/prsg_pkg.sv
// Shared constants for the pseudo-random sequence generator.
package prsg_pkg;

  localparam logic PRSG_FIB = 1'b0;
  localparam logic PRSG_GAL = 1'b1;

  // Maximal-length tap masks for the small widths.
  localparam logic [2:0] PRSG_TAPS3 = 3'b110;
  localparam logic [3:0] PRSG_TAPS4 = 4'b1100;
  localparam logic [4:0] PRSG_TAPS5 = 5'b10100;
  localparam logic [5:0] PRSG_TAPS6 = 6'b110000;
  localparam logic [6:0] PRSG_TAPS7 = 7'b1100000;
  localparam logic [7:0] PRSG_TAPS8 = 8'b10111000;

  // Default tap mask for a given width. Widths outside 3..8 get the 5-bit mask
  // and are expected to override TAPS explicitly.
  function automatic logic [31:0] default_taps(input int w);
    case (w)
      3:       default_taps = 32'(PRSG_TAPS3);
      4:       default_taps = 32'(PRSG_TAPS4);
      6:       default_taps = 32'(PRSG_TAPS6);
      7:       default_taps = 32'(PRSG_TAPS7);
      8:       default_taps = 32'(PRSG_TAPS8);
      default: default_taps = 32'(PRSG_TAPS5);
    endcase
  endfunction

endpackage

// File: rtl/prsg_tick_div.sv
// Clock-enable prescaler: tick once every 2^DIV_BITS enabled cycles.
module prsg_tick_div #(
  parameter int DIV_BITS = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  generate
    if (DIV_BITS == 0) begin : g_pass
      // No prescaling: a step is permitted every cycle.
      logic unused_div;
      assign unused_div = &{1'b0, clk, rst, clr, en};
      assign tick = 1'b1;
    end else begin : g_div
      logic [DIV_BITS-1:0] div_cnt;

      // Free-running counter, frozen while disabled, restarted by load.
      always_ff @(posedge clk) begin
        if (rst || clr)
          div_cnt <= '0;
        else if (en)
          div_cnt <= div_cnt + 1'b1;
      end

      assign tick = &div_cnt;
    end
  endgenerate

endmodule

// File: rtl/lfsr_prsg.sv
// Parametrised Fibonacci/Galois LFSR with seed load, zero-state guard
// and on-line period measurement.
module lfsr_prsg
  import prsg_pkg::*;
#(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED     = '1,
  parameter int               DIV_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             step,
  output logic             lockup,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  logic             tick;
  logic             adv;
  logic [WIDTH-1:0] fib_nxt;
  logic [WIDTH-1:0] gal_nxt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cnt;
  logic             mode_q;

  prsg_tick_div #(.DIV_BITS(DIV_BITS)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (en),
    .tick (tick)
  );

  assign adv     = en & tick & ~load;
  assign bit_out = q[WIDTH-1];

  // Candidate next states for both forms; mode picks one on each advance.
  always_comb begin
    fib_nxt    = {q[WIDTH-2:0], ^(q & TAPS)};
    gal_nxt    = '0;
    gal_nxt[0] = q[WIDTH-1];
    for (int i = 1; i < WIDTH; i++)
      gal_nxt[i] = q[i-1] ^ (q[WIDTH-1] & TAPS[i-1]);
    nxt      = (mode == PRSG_GAL) ? gal_nxt : fib_nxt;
    load_val = (seed_in == '0) ? SEED : seed_in;
  end

  // State update, status pulses and period tracking share one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q            <= SEED;
      step         <= 1'b0;
      lockup       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      ref_q        <= SEED;
      cnt          <= '0;
      mode_q       <= PRSG_FIB;
    end else if (load) begin
      // Load wins over advance; a simultaneous mode change folds into this restart.
      q            <= load_val;
      step         <= 1'b0;
      lockup       <= (seed_in == '0);
      period_valid <= 1'b0;
      ref_q        <= load_val;
      cnt          <= '0;
      mode_q       <= mode;
    end else if (q == '0) begin
      // Unreachable in normal use; recover rather than stick at zero.
      q            <= SEED;
      step         <= 1'b0;
      lockup       <= 1'b1;
      period_valid <= 1'b0;
      ref_q        <= SEED;
      cnt          <= '0;
      mode_q       <= mode;
    end else if (adv) begin
      q      <= nxt;
      step   <= 1'b1;
      lockup <= 1'b0;
      if (mode != mode_q) begin
        // Different polynomial form: previous measurement no longer applies.
        period_valid <= 1'b0;
        ref_q        <= nxt;
        cnt          <= '0;
        mode_q       <= mode;
      end else if (nxt == ref_q) begin
        period       <= cnt + 1'b1;
        period_valid <= 1'b1;
        cnt          <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      step   <= 1'b0;
      lockup <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_prsg.sv
// Directed bench: default config, a 2-bit prescaler config and an 8-bit config.
module tb_lfsr_prsg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic       rst_a, en_a, mode_a, load_a;
  logic [4:0] seed_a, q_a, per_a;
  logic       bit_a, step_a, lock_a, pv_a;

  lfsr_prsg u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .load(load_a),
    .seed_in(seed_a), .q(q_a), .bit_out(bit_a), .step(step_a),
    .lockup(lock_a), .period(per_a), .period_valid(pv_a)
  );

  // Prescaled instance
  logic       rst_b, en_b, mode_b, load_b;
  logic [4:0] seed_b, q_b, per_b;
  logic       bit_b, step_b, lock_b, pv_b;

  lfsr_prsg #(.DIV_BITS(2)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .load(load_b),
    .seed_in(seed_b), .q(q_b), .bit_out(bit_b), .step(step_b),
    .lockup(lock_b), .period(per_b), .period_valid(pv_b)
  );

  // 8-bit instance
  logic       rst_c, en_c, mode_c, load_c;
  logic [7:0] seed_c, q_c, per_c;
  logic       bit_c, step_c, lock_c, pv_c;

  lfsr_prsg #(.WIDTH(8), .TAPS(8'b10111000)) u_c (
    .clk(clk), .rst(rst_c), .en(en_c), .mode(mode_c), .load(load_c),
    .seed_in(seed_c), .q(q_c), .bit_out(bit_c), .step(step_c),
    .lockup(lock_c), .period(per_c), .period_valid(pv_c)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1; en_a = 0; mode_a = 0; load_a = 0; seed_a = '0;
    rst_b = 1; en_b = 0; mode_b = 0; load_b = 0; seed_b = '0;
    rst_c = 1; en_c = 0; mode_c = 0; load_c = 0; seed_c = '0;
    cyc(2);

    // Reset state
    check("rst_q", 32'(q_a), 32'h1F);
    check("rst_bit", 32'(bit_a), 32'h1);
    check("rst_step", 32'(step_a), 32'h0);
    check("rst_lock", 32'(lock_a), 32'h0);
    check("rst_per", 32'(per_a), 32'h0);
    check("rst_pv", 32'(pv_a), 32'h0);

    // Fibonacci sequence
    rst_a = 0; en_a = 1;
    cyc(1); check("fib1", 32'(q_a), 32'h1E); check("fib1_step", 32'(step_a), 32'h1);
    cyc(1); check("fib2", 32'(q_a), 32'h1C); check("fib2_step", 32'(step_a), 32'h1);
    cyc(1); check("fib3", 32'(q_a), 32'h18);
    cyc(1); check("fib4", 32'(q_a), 32'h11);
    cyc(26); check("fib30_pv", 32'(pv_a), 32'h0);
    cyc(1);
    check("fib31_pv", 32'(pv_a), 32'h1);
    check("fib31_per", 32'(per_a), 32'd31);
    check("fib31_q", 32'(q_a), 32'h1F);

    // Zero-seed load mid-run
    load_a = 1; seed_a = 5'h00;
    cyc(1); load_a = 0;
    check("z_q", 32'(q_a), 32'h1F);
    check("z_lock", 32'(lock_a), 32'h1);
    check("z_step", 32'(step_a), 32'h0);
    check("z_pv", 32'(pv_a), 32'h0);
    cyc(1);
    check("z_next_q", 32'(q_a), 32'h1E);
    check("z_next_lock", 32'(lock_a), 32'h0);

    // Non-zero load with en high: no advance on the load cycle
    load_a = 1; seed_a = 5'h0A;
    cyc(1); load_a = 0;
    check("ld_q", 32'(q_a), 32'h0A);
    check("ld_step", 32'(step_a), 32'h0);
    check("ld_lock", 32'(lock_a), 32'h0);
    cyc(30); check("ld30_pv", 32'(pv_a), 32'h0);
    cyc(1);
    check("ld31_pv", 32'(pv_a), 32'h1);
    check("ld31_per", 32'(per_a), 32'd31);
    check("ld31_q", 32'(q_a), 32'h0A);

    // Switch to Galois mid-run: measurement restarts from the new state
    mode_a = 1;
    cyc(1);
    check("gal_q", 32'(q_a), 32'h14);
    check("gal_pv_drop", 32'(pv_a), 32'h0);
    check("gal_step", 32'(step_a), 32'h1);
    cyc(30); check("gal30_pv", 32'(pv_a), 32'h0);
    cyc(1);
    check("gal31_pv", 32'(pv_a), 32'h1);
    check("gal31_per", 32'(per_a), 32'd31);
    check("gal31_q", 32'(q_a), 32'h14);

    // Reset together with load
    rst_a = 1; load_a = 1; seed_a = 5'h05;
    cyc(1);
    check("rl_q", 32'(q_a), 32'h1F);
    check("rl_step", 32'(step_a), 32'h0);
    check("rl_lock", 32'(lock_a), 32'h0);
    check("rl_pv", 32'(pv_a), 32'h0);
    check("rl_per", 32'(per_a), 32'h0);

    // Galois from reset: first advance gives 17
    rst_a = 0; load_a = 0; en_a = 1; mode_a = 1;
    cyc(1); check("galr_q", 32'(q_a), 32'h17);
    cyc(40);
    check("galr_pv", 32'(pv_a), 32'h1);
    check("galr_per", 32'(per_a), 32'd31);

    // Prescaler: steps every 4 cycles
    rst_b = 0; en_b = 1;
    cyc(3);
    check("div3_q", 32'(q_b), 32'h1F);
    check("div3_step", 32'(step_b), 32'h0);
    cyc(1);
    check("div4_q", 32'(q_b), 32'h1E);
    check("div4_step", 32'(step_b), 32'h1);
    cyc(1); check("div5_step", 32'(step_b), 32'h0);
    cyc(3); check("div8_q", 32'(q_b), 32'h1C);
    cyc(1);
    // Freeze one cycle into the phase
    en_b = 0;
    cyc(5);
    check("frz_q", 32'(q_b), 32'h1C);
    check("frz_step", 32'(step_b), 32'h0);
    en_b = 1;
    cyc(2);
    check("res2_q", 32'(q_b), 32'h1C);
    cyc(1);
    check("res3_q", 32'(q_b), 32'h18);
    check("res3_step", 32'(step_b), 32'h1);

    // 8-bit maximal sequence
    rst_c = 0; en_c = 1;
    cyc(254); check("w8_254_pv", 32'(pv_c), 32'h0);
    cyc(1);
    check("w8_pv", 32'(pv_c), 32'h1);
    check("w8_per", 32'(per_c), 32'd255);
    check("w8_q", 32'(q_c), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
